ramblock_fifo_ctrl: RTL
=======================

Name: ramblock_fifo_ctrl

Overview:
Single-clock FIFO controller that initiates every access on the write and read ports of the 256x9 sync-write/sync-read RAM block (DIn/WADDR/WRB, RADDR/RDB, DO1). It converts push/pop requests into RAM cycles and maintains pointers, occupancy, flags and sticky error bits. Both RAM clocks (WCLKS, RCLKS) are tied to this block's CLKS at the next level up.

Parameters:
DW, 9, data width; matches RAM DIn/DO1.
AW, 8, address width; DEPTH = 2**AW = 256 entries.
AFULL_THR, 240, occupancy at or above which ALMOST_FULL asserts (1..DEPTH).

Ports:
CLKS  input  1  clock; also drives RAM WCLKS/RCLKS.
RSTB  input  1  asynchronous active-low reset.
CLEAR  input  1  synchronous flush of pointers, count and error flags.
PUSH  input  1  write request.
PUSH_DATA  input  DW  write data.
POP  input  1  read request.
POP_DATA  output  DW  read data; valid when POP_VALID=1.
POP_VALID  output  1  read data strobe.
FULL  output  1  COUNT == DEPTH.
EMPTY  output  1  COUNT == 0.
ALMOST_FULL  output  1  COUNT >= AFULL_THR.
COUNT  output  AW+1  current occupancy, 0..DEPTH.
OVERFLOW  output  1  sticky: push rejected.
UNDERFLOW  output  1  sticky: pop rejected.
RAM_DIN  output  DW  to RAM DIn.
RAM_WADDR  output  AW  to RAM WADDR.
RAM_WRB  output  1  to RAM WRB, active low.
RAM_RADDR  output  AW  to RAM RADDR.
RAM_RDB  output  1  to RAM RDB, active low.
RAM_DO  input  DW  from RAM DO1.

Behaviour:
- Reset (RSTB=0, asynchronous): wptr=rptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0, POP_VALID=0, OVERFLOW=UNDERFLOW=0.
- RAM_WRB and RAM_RDB are combinational and forced high while RSTB=0.
- push_acc = PUSH & ~FULL & ~CLEAR; pop_acc = POP & ~EMPTY & ~CLEAR. Flags used are the registered state, never the same-cycle request.
- Write: when push_acc, RAM_WRB=0, RAM_WADDR=wptr, RAM_DIN=PUSH_DATA in the same cycle. wptr increments at the edge and wraps 255->0. Otherwise RAM_WRB=1.
- Read: when pop_acc, RAM_RDB=0 and RAM_RADDR=rptr in the same cycle. rptr increments and wraps. POP_VALID=1 in the next cycle (1-cycle latency); POP_DATA=RAM_DO during that cycle. POP_VALID is a registered pop_acc; back-to-back pops give a continuous POP_VALID.
- COUNT: +1 on push only, -1 on pop only, unchanged when both are accepted. FULL, EMPTY and ALMOST_FULL decode from the registered COUNT.
- Full: push rejected and OVERFLOW sets, even with a simultaneous accepted pop. This prevents a same-address read/write hazard (wptr==rptr when full).
- Empty: pop rejected and UNDERFLOW sets, even with a simultaneous accepted push (no fall-through). POP_VALID stays 0 in the next cycle.
- While not full and not empty, wptr != rptr, so simultaneous RAM read and write never address the same entry.
- OVERFLOW/UNDERFLOW stay set until CLEAR or reset.
- CLEAR=1: wptr=rptr=0, COUNT=0, OVERFLOW=UNDERFLOW=0 at the edge. No RAM access that cycle and no error flag from concurrent PUSH/POP. A POP_VALID already pending from the previous cycle still completes.
- Reset mid-operation: any pending POP_VALID is dropped. RAM contents are not cleared and are unreachable after reset.

Test Plan:
- Reset then push 0x001..0x003, then pop x3 -> POP_VALID one cycle after each pop; POP_DATA 0x001, 0x002, 0x003; COUNT 3->0; EMPTY=1.
- Push 256 words 0x100+i -> FULL=1, COUNT=256, ALMOST_FULL from COUNT=240. Extra push -> RAM_WRB=1, OVERFLOW=1, COUNT stays 256.
- Fill to 256, then push+pop same cycle -> pop returns 0x100, push rejected, OVERFLOW=1, COUNT=255.
- Empty FIFO, POP+PUSH(0x1AA) same cycle -> UNDERFLOW=1, POP_VALID=0 next cycle, COUNT=1. Next pop returns 0x1AA.
- Wrap: push/pop 300 words steady at COUNT=5 -> RAM_WADDR and RAM_RADDR wrap 255->0, data order preserved, no flags set.
- CLEAR with COUNT=10 and PUSH=1 -> COUNT=0, EMPTY=1, flags cleared, RAM_WRB=1. Async RSTB low mid-pop -> POP_VALID=0 immediately.

Source files
------------

// File: rtl/ramblock_fifo_ctrl_if.sv
// FIFO user-side bundle: push/pop handshake, read data and status flags.
// The controller takes the slave view; the block driving requests takes the master view.
interface ramblock_fifo_ctrl_if #(
    parameter int unsigned DW = 9,
    parameter int unsigned AW = 8
) ();

    logic          clear;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output clear,
        output push,
        output push_data,
        output pop,
        input  pop_data,
        input  pop_valid,
        input  full,
        input  empty,
        input  almost_full,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  clear,
        input  push,
        input  push_data,
        input  pop,
        output pop_data,
        output pop_valid,
        output full,
        output empty,
        output almost_full,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/ramblock_fifo_ctrl.sv
// Single-clock FIFO controller in front of a 256x9 sync-write/sync-read RAM block.
// Turns push/pop requests into RAM write/read cycles and tracks pointers, occupancy,
// status flags and sticky overflow/underflow bits. RAM read data has one cycle of
// latency, so pop_valid is the accepted pop delayed by one edge.
module ramblock_fifo_ctrl #(
    parameter int unsigned DW        = 9,
    parameter int unsigned AW        = 8,
    parameter int unsigned AFULL_THR = 240
) (
    input  logic          clks_i,
    input  logic          rstb_ni,
    ramblock_fifo_ctrl_if.slave fifo_if,
    output logic [DW-1:0] ram_din_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic          ram_wrb_o,
    output logic [AW-1:0] ram_raddr_o,
    output logic          ram_rdb_o,
    input  logic [DW-1:0] ram_do_i
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW:0] DepthCnt  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AfullCnt  = (AW + 1)'(AFULL_THR);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_valid_q, pop_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full, empty;
    logic push_acc, pop_acc;

    // Flags decode from the registered count only, so acceptance never depends on
    // a same-cycle request. Rejecting pushes when full keeps wptr != rptr for any
    // simultaneous read/write, avoiding a same-address RAM hazard.
    always_comb begin
        full     = (count_q == DepthCnt);
        empty    = (count_q == '0);
        push_acc = fifo_if.push & ~full  & ~fifo_if.clear;
        pop_acc  = fifo_if.pop  & ~empty & ~fifo_if.clear;
    end

    // RAM strobes: combinational, held inactive (high) while reset is asserted.
    always_comb begin
        ram_din_o   = fifo_if.push_data;
        ram_waddr_o = wptr_q;
        ram_raddr_o = rptr_q;
        ram_wrb_o   = ~(push_acc & rstb_ni);
        ram_rdb_o   = ~(pop_acc & rstb_ni);
    end

    // Next-state for pointers, occupancy, read strobe and sticky error bits.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q  | (fifo_if.push & full  & ~fifo_if.clear);
        underflow_d = underflow_q | (fifo_if.pop  & empty & ~fifo_if.clear);

        if (push_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_acc) begin
            rptr_d = rptr_q + 1'b1;
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flush; a pop_valid already registered last cycle is unaffected.
        if (fifo_if.clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // State registers; async reset drops any pending pop_valid immediately.
    always_ff @(posedge clks_i or negedge rstb_ni) begin
        if (!rstb_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // User-facing outputs.
    always_comb begin
        fifo_if.pop_data    = ram_do_i;
        fifo_if.pop_valid   = pop_valid_q;
        fifo_if.full        = full;
        fifo_if.empty       = empty;
        fifo_if.almost_full = (count_q >= AfullCnt);
        fifo_if.count       = count_q;
        fifo_if.overflow    = overflow_q;
        fifo_if.underflow   = underflow_q;
    end

endmodule
